mult_datapath: RTL and testbench



---
 rtl/mult_datapath_pkg.sv | 11 +
 rtl/mult_out_reg.sv | 52 +++++
 rtl/mult_datapath.sv | 88 ++++++++
 tb/tb_mult_datapath.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_datapath_pkg.sv
// Shared constants for the shift-add multiplier datapath.
package mult_datapath_pkg;

    localparam int unsigned MULT_N = 4;
    localparam int unsigned PROD_W = 2 * MULT_N;

    // {en, flag} encodings driven by the sequencing controller
    localparam logic [1:0] CTRL_STEP = 2'b10;
    localparam logic [1:0] CTRL_DONE = 2'b11;

endpackage

// File: rtl/mult_out_reg.sv
// Valid/ready product holding register; flags products overwritten before acceptance.
module mult_out_reg
    import mult_datapath_pkg::*;
#(
    parameter int unsigned W = PROD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         lost_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         lost_q, lost_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            lost_q  <= lost_d;
        end
    end

    // A load on the accepting edge replaces the product without counting it as lost
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        lost_d  = 1'b0;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            lost_d  = valid_q && !ready_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign lost_o  = lost_q;

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier core driven by the controller's en/flag; product leaves via mult_out_reg.
module mult_datapath
    import mult_datapath_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             en,
    input  logic             flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic             lost
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(N + 1);

    logic [PW-1:0] mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] step_cnt_q, step_cnt_d;
    logic          done_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            step_cnt_q <= '0;
        end else begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // start outranks step/done and abandons any multiply in flight
    always_comb begin
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        step_cnt_d = step_cnt_q;
        done_c     = 1'b0;
        if (start) begin
            mcand_d    = PW'(a);
            mplier_d   = b;
            acc_d      = '0;
            step_cnt_d = '0;
        end else begin
            case ({en, flag})
                CTRL_STEP: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d    = mcand_q << 1;
                    mplier_d   = mplier_q >> 1;
                    step_cnt_d = step_cnt_q + CW'(1);
                end
                CTRL_DONE: done_c = 1'b1;
                default: ;
            endcase
        end
    end

    // A done without exactly N preceding steps means the controller is out of sync
    step_cnt_chk: assert property (@(posedge clk) disable iff (rst)
        done_c |-> (step_cnt_q == CW'(N)));

    mult_out_reg #(
        .W (PW)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (done_c),
        .data_i  (acc_q),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (product),
        .lost_o  (lost)
    );

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: controller timing model plus a transaction-level product scoreboard.
module tb_mult_datapath;

    localparam int N  = 4;
    localparam int PW = 2 * N;
    localparam int LAT = N + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          en;
    logic          flag;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] product;
    logic          lost;

    int total = 0;
    int bad   = 0;

    // scoreboard state
    int            edge_no = 0;
    bit            pend = 0;
    int            pend_due = 0;
    int            pend_val = 0;
    bit            exp_valid = 0;
    int            exp_prod = 0;
    bit            exp_lost = 0;

    always #5 clk = ~clk;

    mult_datapath #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .en        (en),
        .flag      (flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .lost      (lost)
    );

    // Controller: one ramp cycle after start, N busy cycles, then busy+flag for the done cycle
    int ccyc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ccyc <= 0; en <= 1'b0; flag <= 1'b0;
        end else if (start) begin
            ccyc <= 1; en <= 1'b0; flag <= 1'b0;
        end else if (ccyc != 0) begin
            en   <= (ccyc <= N + 1);
            flag <= (ccyc == N + 1);
            ccyc <= (ccyc == N + 1) ? 0 : ccyc + 1;
        end else begin
            en <= 1'b0; flag <= 1'b0;
        end
    end

    task automatic check_outputs(input string tag);
        total++;
        assert (out_valid === exp_valid) else begin
            bad++;
            $error("FAIL %s out_valid got=%0b exp=%0b", tag, out_valid, exp_valid);
        end
        total++;
        assert (product === PW'(exp_prod)) else begin
            bad++;
            $error("FAIL %s product got=%0d exp=%0d", tag, product, exp_prod);
        end
        total++;
        assert (lost === exp_lost) else begin
            bad++;
            $error("FAIL %s lost got=%0b exp=%0b", tag, lost, exp_lost);
        end
    endtask

    // One clock edge: advance the reference model with the sampled inputs, then compare
    task automatic tick(input string tag);
        @(posedge clk);
        edge_no++;
        if (rst) begin
            pend = 0; exp_valid = 0; exp_prod = 0; exp_lost = 0;
        end else if (start) begin
            pend = 1; pend_due = edge_no + LAT; pend_val = int'(a) * int'(b);
            exp_lost = 0;
            if (exp_valid && out_ready) exp_valid = 0;
        end else if (pend && edge_no == pend_due) begin
            pend = 0;
            exp_lost = exp_valid && !out_ready;
            exp_valid = 1;
            exp_prod = pend_val;
        end else begin
            exp_lost = 0;
            if (exp_valid && out_ready) exp_valid = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic do_start(input int av, input int bv, input string tag);
        a = N'(av); b = N'(bv); start = 1'b1;
        tick(tag);
        start = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        pend = 0; exp_valid = 0; exp_prod = 0; exp_lost = 0;
        check_outputs(tag);
        ticks(2, tag);
        rst = 1'b0;
    endtask

    initial begin
        // reset values
        #1;
        check_outputs("reset");
        ticks(2, "reset");
        rst = 1'b0;
        ticks(2, "idle");

        // 13*11 with ready high
        out_ready = 1'b1;
        do_start(13, 11, "m13x11");
        ticks(LAT - 1, "m13x11_wait");
        tick("m13x11_out");
        total++;
        assert (out_valid === 1'b1 && product === PW'(143)) else begin
            bad++;
            $error("FAIL m13x11_direct got v=%0b p=%0d exp v=1 p=143", out_valid, product);
        end
        tick("m13x11_clear");

        // corner operands
        do_start(0, 15, "m0x15");   ticks(LAT + 1, "m0x15");
        do_start(15, 15, "m15x15"); ticks(LAT + 1, "m15x15");
        do_start(1, 1, "m1x1");     ticks(LAT + 1, "m1x1");
        do_start(8, 2, "m8x2");     ticks(LAT + 1, "m8x2");

        // hold under backpressure, then a single accept
        out_ready = 1'b0;
        do_start(9, 7, "hold");
        ticks(LAT + 10, "hold");
        out_ready = 1'b1;
        tick("hold_accept");
        out_ready = 1'b0;
        ticks(2, "hold_after");

        // overwrite of an unaccepted product pulses lost
        do_start(5, 6, "ovw1");
        ticks(LAT, "ovw1");
        do_start(3, 4, "ovw2");
        ticks(LAT + 2, "ovw2");
        total++;
        assert (product === PW'(12)) else begin
            bad++;
            $error("FAIL ovw_direct got=%0d exp=12", product);
        end
        out_ready = 1'b1;
        tick("ovw_drain");

        // same, but the consumer accepts on the second done edge
        out_ready = 1'b0;
        do_start(5, 6, "acc1");
        ticks(LAT, "acc1");
        do_start(3, 4, "acc2");
        ticks(LAT - 1, "acc2");
        out_ready = 1'b1;
        tick("acc2_done");
        out_ready = 1'b0;
        ticks(2, "acc2_after");
        out_ready = 1'b1;
        tick("acc_drain");

        // restart abandons the first operation
        do_start(15, 15, "abandon1");
        ticks(1, "abandon1");
        do_start(2, 3, "abandon2");
        ticks(LAT + 2, "abandon2");

        // reset during the second step of 10*10
        do_start(10, 10, "rst_mid");
        ticks(2, "rst_mid");
        do_reset("rst_mid_async");
        ticks(LAT + 2, "rst_mid_quiet");
        do_start(4, 5, "after_rst");
        ticks(LAT + 1, "after_rst");

        // random operands, gaps and backpressure
        for (int k = 0; k < 40; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            do_start(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
            for (int j = 0, g = int'($urandom_range(1, 10)); j < g; j++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick("rand");
            end
        end
        out_ready = 1'b1;
        ticks(LAT + 2, "rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
